// File: rtl/s3_chien_forney.sv
`default_nettype none
// -----------------------------------------------------------------------------
// s3_chien_forney : serial Chien search + Forney magnitude, RS t=2 over GF(2^8)
// Optional macro CHIEN_ERRCNT_EN adds cs_nerr/cs_fail on cs_last.  Rev 1.0
// -----------------------------------------------------------------------------

module gf2m8_multi (
   input  logic [7:0] a_i,
   input  logic [7:0] b_i,
   output logic [7:0] p_o
);
   logic [7:0] w_acc;
   logic [7:0] w_sh;

   always_comb begin
      w_acc = 8'h00;
      w_sh  = a_i;
      for (int i = 0; i < 8; i++) begin
         if (b_i[i]) w_acc = w_acc ^ w_sh;
         w_sh = {w_sh[6:0], 1'b0} ^ (w_sh[7] ? 8'h1D : 8'h00);
      end
   end

   assign p_o = w_acc;
endmodule

module gf2m8_inverse (
   input  logic [7:0] a_i,
   output logic [7:0] inv_o
);
   // a^254 = prod of a^(2^k), k=1..7; yields 00 for a==00
   logic [7:0] w_sq  [0:7];
   logic [7:0] w_acc [0:7];

   assign w_sq[0]  = a_i;
   assign w_acc[0] = 8'h01;

   for (genvar i = 1; i < 8; i++) begin : g_pow
      gf2m8_multi u_sq  (.a_i(w_sq[i-1]),  .b_i(w_sq[i-1]), .p_o(w_sq[i]));
      gf2m8_multi u_acc (.a_i(w_acc[i-1]), .b_i(w_sq[i]),   .p_o(w_acc[i]));
   end

   assign inv_o = w_acc[7];
endmodule

module s3_chien_forney #(
   parameter int N = 255
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       kes_done,
   input  logic [7:0] rs_lambda0,
   input  logic [7:0] rs_lambda1,
   input  logic [7:0] rs_lambda2,
   input  logic [7:0] rs_omega0,
   input  logic [7:0] rs_omega1,
   output logic       cs_busy,
   output logic       cs_valid,
   output logic [7:0] cs_pos,
   output logic [7:0] cs_err,
`ifdef CHIEN_ERRCNT_EN
   output logic [1:0] cs_nerr,
   output logic [0:0] cs_fail,
`endif
   output logic       cs_last
);
   function automatic logic [7:0] f_mul_a(input logic [7:0] x);
      return {x[6:0], 1'b0} ^ (x[7] ? 8'h1D : 8'h00);
   endfunction

   function automatic logic [7:0] f_div_a(input logic [7:0] x);
      return x[0] ? (((x ^ 8'h1D) >> 1) | 8'h80) : (x >> 1);
   endfunction

   function automatic logic [7:0] f_alpha_pow(input int e);
      logic [7:0] r;
      r = 8'h01;
      for (int i = 0; i < e; i++) r = f_mul_a(r);
      return r;
   endfunction

   localparam logic [7:0] c_X0   = f_alpha_pow(N - 1);
   localparam logic [7:0] c_K1   = f_alpha_pow((255 - (N - 1)) % 255);
   localparam logic [7:0] c_K2   = f_alpha_pow((510 - 2 * (N - 1)) % 255);
   localparam logic [7:0] c_PMAX = 8'(N - 1);

   typedef enum logic [1:0] {IDLE, SETUP, SCAN} state_t;

   state_t     state_q, state_d;
   logic       busy_q, busy_d;
   logic [7:0] l0_q, l0_d, l1_q, l1_d, l2_q, l2_d, w0_q, w0_d, w1_q, w1_d;
   logic [7:0] inv_q, inv_d, c1_q, c1_d, c2_q, c2_d, d1_q, d1_d, x_q, x_d;
   logic [7:0] cnt_q, cnt_d;
   logic       valid_q, valid_d, last_q, last_d;
   logic [7:0] pos_q, pos_d, err_q, err_d;

   logic [7:0] w_c1, w_c2, w_d1, w_inv, w_om, w_xo, w_mag;
   logic       w_root;

   gf2m8_multi   u_m_c1  (.a_i(l1_q), .b_i(c_K1),  .p_o(w_c1));
   gf2m8_multi   u_m_c2  (.a_i(l2_q), .b_i(c_K2),  .p_o(w_c2));
   gf2m8_multi   u_m_d1  (.a_i(w1_q), .b_i(c_K1),  .p_o(w_d1));
   gf2m8_inverse u_inv   (.a_i(l1_q), .inv_o(w_inv));
   gf2m8_multi   u_m_xo  (.a_i(x_q),  .b_i(w_om),  .p_o(w_xo));
   gf2m8_multi   u_m_err (.a_i(w_xo), .b_i(inv_q), .p_o(w_mag));

   // Lambda(alpha^-p) and Omega(alpha^-p) from the running terms
   assign w_root = ((l0_q ^ c1_q ^ c2_q) == 8'h00);
   assign w_om   = w0_q ^ d1_q;

`ifdef CHIEN_ERRCNT_EN
   logic [1:0] nroot_q, nroot_d, nerr_q, nerr_d, w_nsum, w_deg;
   logic       l1z_q, l1z_d, fail_q, fail_d;

   assign w_nsum = (w_root && nroot_q != 2'd3) ? nroot_q + 2'd1 : nroot_q;
   assign w_deg  = (l2_q != 8'h00) ? 2'd2 : (l1_q != 8'h00) ? 2'd1 : 2'd0;
`endif

   always_comb begin
      state_d = state_q;
      busy_d  = busy_q;
      l0_d    = l0_q;
      l1_d    = l1_q;
      l2_d    = l2_q;
      w0_d    = w0_q;
      w1_d    = w1_q;
      inv_d   = inv_q;
      c1_d    = c1_q;
      c2_d    = c2_q;
      d1_d    = d1_q;
      x_d     = x_q;
      cnt_d   = cnt_q;
      valid_d = 1'b0;
      pos_d   = 8'h00;
      err_d   = 8'h00;
      last_d  = 1'b0;
`ifdef CHIEN_ERRCNT_EN
      nroot_d = nroot_q;
      l1z_d   = l1z_q;
      nerr_d  = 2'd0;
      fail_d  = 1'b0;
`endif
      // busy spans the cs_last cycle, so a kes_done in that cycle is dropped
      if (last_q) busy_d = 1'b0;
      case (state_q)
         IDLE: begin
            if (kes_done && !busy_q) begin
               state_d = SETUP;
               busy_d  = 1'b1;
               l0_d    = rs_lambda0;
               l1_d    = rs_lambda1;
               l2_d    = rs_lambda2;
               w0_d    = rs_omega0;
               w1_d    = rs_omega1;
`ifdef CHIEN_ERRCNT_EN
               nroot_d = 2'd0;
               l1z_d   = 1'b0;
`endif
            end
         end
         SETUP: begin
            inv_d   = w_inv;
            c1_d    = w_c1;
            c2_d    = w_c2;
            d1_d    = w_d1;
            x_d     = c_X0;
            cnt_d   = c_PMAX;
            state_d = SCAN;
         end
         SCAN: begin
            valid_d = 1'b1;
            pos_d   = cnt_q;
            err_d   = w_root ? w_mag : 8'h00;
            last_d  = (cnt_q == 8'h00);
            c1_d    = f_mul_a(c1_q);
            c2_d    = f_mul_a(f_mul_a(c2_q));
            d1_d    = f_mul_a(d1_q);
            x_d     = f_div_a(x_q);
            cnt_d   = cnt_q - 8'h01;
`ifdef CHIEN_ERRCNT_EN
            nroot_d = w_nsum;
            l1z_d   = l1z_q | (w_root && l1_q == 8'h00);
            if (cnt_q == 8'h00) begin
               nerr_d = w_nsum;
               fail_d = (w_nsum != w_deg) || l1z_d;
            end
`endif
            if (cnt_q == 8'h00) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         busy_q  <= 1'b0;
         l0_q    <= 8'h00;
         l1_q    <= 8'h00;
         l2_q    <= 8'h00;
         w0_q    <= 8'h00;
         w1_q    <= 8'h00;
         inv_q   <= 8'h00;
         c1_q    <= 8'h00;
         c2_q    <= 8'h00;
         d1_q    <= 8'h00;
         x_q     <= 8'h00;
         cnt_q   <= 8'h00;
         valid_q <= 1'b0;
         pos_q   <= 8'h00;
         err_q   <= 8'h00;
         last_q  <= 1'b0;
`ifdef CHIEN_ERRCNT_EN
         nroot_q <= 2'd0;
         l1z_q   <= 1'b0;
         nerr_q  <= 2'd0;
         fail_q  <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         busy_q  <= busy_d;
         l0_q    <= l0_d;
         l1_q    <= l1_d;
         l2_q    <= l2_d;
         w0_q    <= w0_d;
         w1_q    <= w1_d;
         inv_q   <= inv_d;
         c1_q    <= c1_d;
         c2_q    <= c2_d;
         d1_q    <= d1_d;
         x_q     <= x_d;
         cnt_q   <= cnt_d;
         valid_q <= valid_d;
         pos_q   <= pos_d;
         err_q   <= err_d;
         last_q  <= last_d;
`ifdef CHIEN_ERRCNT_EN
         nroot_q <= nroot_d;
         l1z_q   <= l1z_d;
         nerr_q  <= nerr_d;
         fail_q  <= fail_d;
`endif
      end
   end

   assign cs_busy  = busy_q;
   assign cs_valid = valid_q;
   assign cs_pos   = pos_q;
   assign cs_err   = err_q;
   assign cs_last  = last_q;
`ifdef CHIEN_ERRCNT_EN
   assign cs_nerr  = nerr_q;
   assign cs_fail  = fail_q;
`endif
endmodule
`default_nettype wire
